issue_queue: RTL

- Dual-wide in-order instruction buffer between the dual decode stage and the issue stage.
- Accepts up to two decoded instructions per cycle from decode.
- Presents the two oldest entries to the issue logic, which operand-reads them and forms issue packets.
- Issue logic retires 0, 1 or 2 entries per cycle from the head.
- Supports a pipeline flush for branch mispredict and exceptions.

---
 rtl/issue_queue_if.sv | 32 +++
 rtl/issue_queue.sv | 80 ++++++++
 2 files changed

// File: rtl/issue_queue_if.sv
// issue_queue_if: decode/issue-side bundle for the dual-wide in-order issue queue.
`default_nettype none

interface issue_queue_if #(
   parameter int ENTRY_W = 128,
   parameter int DEPTH   = 8
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic               flush;
   logic [1:0]         in_valid;
   logic [ENTRY_W-1:0] in_data0;
   logic [ENTRY_W-1:0] in_data1;
   logic               in_ready;
   logic [1:0]         out_valid;
   logic [ENTRY_W-1:0] out_data0;
   logic [ENTRY_W-1:0] out_data1;
   logic [1:0]         issue_cnt;
   logic [CNT_W-1:0]   count;

   modport master (
      output flush, in_valid, in_data0, in_data1, issue_cnt,
      input  in_ready, out_valid, out_data0, out_data1, count
   );

   modport slave (
      input  flush, in_valid, in_data0, in_data1, issue_cnt,
      output in_ready, out_valid, out_data0, out_data1, count
   );
endinterface

`default_nettype wire

// File: rtl/issue_queue.sv
// issue_queue: dual-wide in-order buffer between decode and issue.
// Up to two entries in and out per cycle; flush clears; outputs come only from registered state.
`default_nettype none

module issue_queue #(
   parameter int ENTRY_W = 128,
   parameter int DEPTH   = 8
) (
   input  wire logic     clk,
   input  wire logic     resetn,
   issue_queue_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   head_q, head_d, head1;
   logic [PTR_W-1:0]   tail_q, tail_d, tail1;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [1:0]         enq_n, deq_req, deq_n;
   logic               in_ready, wr0, wr1;

   always_comb begin
      in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(2);
      // in_valid=10 never writes: slot 1 is only taken together with slot 0
      wr0      = in_ready && bus.in_valid[0] && !bus.flush;
      wr1      = wr0 && bus.in_valid[1];
      enq_n    = 2'(wr0) + 2'(wr1);
      deq_req  = (bus.issue_cnt == 2'd0) ? 2'd0 :
                 (bus.issue_cnt == 2'd1) ? 2'd1 : 2'd2;
      deq_n    = (CNT_W'(deq_req) > count_q) ? count_q[1:0] : deq_req;
      head1    = head_q + PTR_W'(1);
      tail1    = tail_q + PTR_W'(1);
      head_d   = head_q + PTR_W'(deq_n);
      tail_d   = tail_q + PTR_W'(enq_n);
      count_d  = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
      if (bus.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked entirely by count_q.
   always_ff @(posedge clk) begin
      if (wr0) mem_q[tail_q] <= bus.in_data0;
      if (wr1) mem_q[tail1]  <= bus.in_data1;
   end

   always_comb begin
      bus.in_ready  = in_ready;
      bus.count     = count_q;
      bus.out_valid = {count_q >= CNT_W'(2), count_q != '0};
      bus.out_data0 = (count_q != '0)         ? mem_q[head_q] : '0;
      bus.out_data1 = (count_q >= CNT_W'(2))  ? mem_q[head1]  : '0;
   end

   always_ff @(posedge clk) begin
      if (resetn && !bus.flush) begin
         assert (bus.in_valid != 2'b10)
            else $warning("issue_queue: in_valid=10 ignored");
         assert (CNT_W'(deq_req) <= count_q)
            else $warning("issue_queue: issue_cnt exceeds occupancy, clamped");
      end
   end
endmodule

`default_nettype wire
